// File: rtl/ps2_kbd_rx_fifo.sv
// PS/2 keyboard receiver: frame deserialiser, E0/F0 prefix decoder and event FIFO
// with valid/ready drain, sticky error flags and a make-event counter.
module ps2_kbd_rx_fifo #(
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 3,
  parameter int TIMEOUT_CYC = 50000,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  input  logic              out_ready,
  input  logic              clr_err,
  output logic              out_valid,
  output logic [7:0]        out_code,
  output logic              out_break,
  output logic              out_ext,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              parity_err,
  output logic              frame_err,
  output logic [CNT_W-1:0]  press_count
);

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_E0   = 2'd1;
  localparam logic [1:0] ST_F0   = 2'd2;
  localparam logic [1:0] ST_E0F0 = 2'd3;
  localparam logic [7:0] B_E0    = 8'hE0;
  localparam logic [7:0] B_F0    = 8'hF0;

  // Start bit low, stop bit high, data plus parity bit odd.
  function automatic logic frame_ok(input logic [9:0] bits, input logic stop);
    return (bits[0] == 1'b0) && (stop == 1'b1) && ((^bits[9:1]) == 1'b1);
  endfunction

  logic [2:0]        sync_r;
  logic              sample_s;
  logic [3:0]        bit_cnt_r;
  logic [9:0]        shift_r;
  logic [TO_W-1:0]   to_cnt_r;
  logic              timeout_s, frame_end_s, byte_ok_s, byte_bad_s;
  logic [7:0]        byte_s;
  logic [1:0]        st_r, st_nxt_s;
  logic              push_s, push_ext_s, push_brk_s;
  logic [9:0]        mem_r [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [ADDR_W:0]   level_r, level_nxt_s;
  logic              valid_r, full_s, pop_s, push_ok_s, drop_s;
  logic              ovf_r, perr_r, ferr_r;
  logic [CNT_W-1:0]  press_r;

  assign sample_s    = sync_r[2] & ~sync_r[1];
  assign frame_end_s = sample_s & (bit_cnt_r == 4'd10);
  assign byte_ok_s   = frame_end_s & frame_ok(shift_r, ps2_data);
  assign byte_bad_s  = frame_end_s & ~frame_ok(shift_r, ps2_data);
  assign byte_s      = shift_r[8:1];
  assign timeout_s   = (bit_cnt_r != 4'd0) & ~sample_s & (to_cnt_r == TO_LAST);

  assign full_s    = (level_r == LVL_FULL);
  assign pop_s     = valid_r & out_ready;
  assign push_ok_s = push_s & (~full_s | pop_s);
  assign drop_s    = push_s & full_s & ~pop_s;

  // ps2_clk synchroniser; idles high so reset never fakes a falling edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_r <= 3'b111;
    else      sync_r <= {sync_r[1:0], ps2_clk};
  end

  // Bit collection and inter-edge timeout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_r <= 4'd0;
      shift_r   <= 10'd0;
      to_cnt_r  <= '0;
    end else if (sample_s) begin
      to_cnt_r <= '0;
      if (bit_cnt_r == 4'd10) begin
        bit_cnt_r <= 4'd0;
      end else begin
        shift_r[bit_cnt_r] <= ps2_data;
        bit_cnt_r          <= bit_cnt_r + 4'd1;
      end
    end else if (bit_cnt_r != 4'd0) begin
      if (timeout_s) begin
        bit_cnt_r <= 4'd0;
        to_cnt_r  <= '0;
      end else begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
    end else begin
      to_cnt_r <= '0;
    end
  end

  // Prefix decoder: a bad frame leaves the state alone, a timeout abandons it
  always_comb begin
    st_nxt_s   = st_r;
    push_s     = 1'b0;
    push_ext_s = 1'b0;
    push_brk_s = 1'b0;
    if (byte_ok_s) begin
      case (st_r)
        ST_IDLE: begin
          if (byte_s == B_E0)      st_nxt_s = ST_E0;
          else if (byte_s == B_F0) st_nxt_s = ST_F0;
          else                     push_s   = 1'b1;
        end
        ST_E0: begin
          if (byte_s == B_F0)      st_nxt_s = ST_E0F0;
          else if (byte_s == B_E0) st_nxt_s = ST_E0;
          else begin
            st_nxt_s   = ST_IDLE;
            push_s     = 1'b1;
            push_ext_s = 1'b1;
          end
        end
        ST_F0, ST_E0F0: begin
          st_nxt_s   = ST_IDLE;
          push_s     = (byte_s != B_E0) && (byte_s != B_F0);
          push_ext_s = (st_r == ST_E0F0);
          push_brk_s = 1'b1;
        end
        default: st_nxt_s = ST_IDLE;
      endcase
    end else if (timeout_s) begin
      st_nxt_s = ST_IDLE;
    end else begin
      st_nxt_s = st_r;
    end
  end

  // Occupancy update
  always_comb begin
    level_nxt_s = level_r;
    if (push_ok_s && !pop_s)      level_nxt_s = level_r + {{ADDR_W{1'b0}}, 1'b1};
    else if (pop_s && !push_ok_s) level_nxt_s = level_r - {{ADDR_W{1'b0}}, 1'b1};
    else                          level_nxt_s = level_r;
  end

  // Decoder state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_r <= ST_IDLE;
    else      st_r <= st_nxt_s;
  end

  // FIFO storage, pointers and level; simultaneous push/pop allowed when full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 10'd0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= {push_ext_s, push_brk_s, byte_s};
        wr_ptr_r        <= wr_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      level_r <= level_nxt_s;
      valid_r <= (level_nxt_s != '0);
    end
  end

  // Sticky flags (set beats clear) and make-event counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r   <= 1'b0;
      perr_r  <= 1'b0;
      ferr_r  <= 1'b0;
      press_r <= '0;
    end else begin
      ovf_r  <= drop_s     | (ovf_r  & ~clr_err);
      perr_r <= byte_bad_s | (perr_r & ~clr_err);
      ferr_r <= timeout_s  | (ferr_r & ~clr_err);
      if (push_ok_s && !push_brk_s) press_r <= press_r + CNT_W'(1);
    end
  end

  assign out_valid   = valid_r;
  assign out_code    = mem_r[rd_ptr_r][7:0];
  assign out_break   = mem_r[rd_ptr_r][8];
  assign out_ext     = mem_r[rd_ptr_r][9];
  assign level       = level_r;
  assign overflow    = ovf_r;
  assign parity_err  = perr_r;
  assign frame_err   = ferr_r;
  assign press_count = press_r;

endmodule

// File: tb/tb_ps2_kbd_rx_fifo.sv
// Bench for ps2_kbd_rx_fifo: table of single-frame vectors plus hand-written
// sequences for overflow, full push+pop, error clearing and timeout.
module tb_ps2_kbd_rx_fifo;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TO    = 400;
  localparam int CW    = 8;
  localparam int NV    = 21;

  logic          clk = 1'b0, rst = 1'b0;
  logic          ps2_clk = 1'b1, ps2_data = 1'b1, out_ready = 1'b0, clr_err = 1'b0;
  logic          out_valid, out_break, out_ext, overflow, parity_err, frame_err;
  logic [7:0]    out_code;
  logic [AW:0]   level;
  logic [CW-1:0] press_count;

  int total = 0;
  int bad   = 0;
  int exp_press = 0;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       pop;
    logic       exp_valid;
    logic [7:0] exp_code;
    logic       exp_brk;
    logic       exp_ext;
    logic [3:0] exp_level;
    logic [7:0] exp_press;
    logic       exp_perr;
  } vec_t;
  vec_t vecs [NV];

  ps2_kbd_rx_fifo #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_ready(out_ready), .clr_err(clr_err), .out_valid(out_valid),
    .out_code(out_code), .out_break(out_break), .out_ext(out_ext),
    .level(level), .overflow(overflow), .parity_err(parity_err),
    .frame_err(frame_err), .press_count(press_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // pulse=1 raises out_ready for exactly the clk cycle whose edge consumes this bit
  task automatic send_bit(input logic b, input logic pulse);
    @(negedge clk); ps2_data = b;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    if (pulse) begin
      repeat (2) @(negedge clk); out_ready = 1'b1;
      @(negedge clk); out_ready = 1'b0;
      repeat (7) @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic pulse);
    logic [10:0] bits;
    bits = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], (i == 10) ? pulse : 1'b0);
  endtask

  task automatic pop_one();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
  endtask

  initial begin
    //          data   bad   pop   vld   code   brk   ext   lvl   press perr
    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0, 4'd1, 8'd1, 1'b0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'd1, 1'b0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b1, 1'b0, 4'd1, 8'd1, 1'b0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'd1, 1'b0};
    vecs[4]  = '{8'h75, 1'b0, 1'b1, 1'b1, 8'h75, 1'b0, 1'b1, 4'd1, 8'd2, 1'b0};
    vecs[5]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'd2, 1'b0};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'd2, 1'b0};
    vecs[7]  = '{8'h75, 1'b0, 1'b1, 1'b1, 8'h75, 1'b1, 1'b1, 4'd1, 8'd2, 1'b0};
    vecs[8]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'd2, 1'b0};
    vecs[9]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'd2, 1'b1};
    vecs[10] = '{8'h33, 1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 4'd1, 8'd2, 1'b1};
    vecs[11] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'd2, 1'b1};
    vecs[12] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'd2, 1'b1};
    vecs[13] = '{8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 4'd1, 8'd3, 1'b1};
    vecs[14] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'd3, 1'b1};
    vecs[15] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'd3, 1'b1};
    vecs[16] = '{8'h6B, 1'b0, 1'b1, 1'b1, 8'h6B, 1'b0, 1'b1, 4'd1, 8'd4, 1'b1};
    vecs[17] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'd4, 1'b1};
    vecs[18] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'd4, 1'b1};
    vecs[19] = '{8'hE0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'd4, 1'b1};
    vecs[20] = '{8'h12, 1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0, 4'd1, 8'd5, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst valid", out_valid, 0);
    chk("rst level", level, 0);
    chk("rst flags", {overflow, parity_err, frame_err}, 0);
    chk("rst press", press_count, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven single-frame vectors
    for (int i = 0; i < NV; i++) begin
      send_frame(vecs[i].data, vecs[i].bad_par, 1'b0);
      chk($sformatf("v%0d valid", i), out_valid, vecs[i].exp_valid);
      chk($sformatf("v%0d level", i), level, vecs[i].exp_level);
      chk($sformatf("v%0d press", i), press_count, vecs[i].exp_press);
      chk($sformatf("v%0d perr", i), parity_err, vecs[i].exp_perr);
      if (vecs[i].exp_valid) begin
        chk($sformatf("v%0d code", i), out_code, vecs[i].exp_code);
        chk($sformatf("v%0d brk", i), out_break, vecs[i].exp_brk);
        chk($sformatf("v%0d ext", i), out_ext, vecs[i].exp_ext);
      end
      if (vecs[i].pop) begin
        pop_one();
        chk($sformatf("v%0d popped level", i), level, 0);
      end
    end
    exp_press = 5;

    // Clearing parity_err, then a normal frame
    pulse_clr();
    chk("clr perr", parity_err, 0);
    send_frame(8'h1C, 1'b0, 1'b0);
    exp_press++;
    chk("after clr code", out_code, 8'h1C);
    chk("after clr level", level, 1);
    chk("after clr press", press_count, exp_press);
    pop_one();

    // Overflow: 9 makes into 8 entries, 0x1E dropped
    for (int i = 0; i < 9; i++) send_frame(8'h16 + 8'(i), 1'b0, 1'b0);
    exp_press += 8;
    chk("ovf level", level, 8);
    chk("ovf flag", overflow, 1);
    chk("ovf press", press_count, exp_press);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf drain%0d valid", i), out_valid, 1);
      chk($sformatf("ovf drain%0d code", i), out_code, 8'h16 + 8'(i));
      pop_one();
    end
    chk("ovf empty valid", out_valid, 0);
    chk("ovf empty level", level, 0);
    pop_one();
    chk("empty pop level", level, 0);

    // Full FIFO with a pop on the same edge as a new push
    pulse_clr();
    chk("clr ovf", overflow, 0);
    for (int i = 0; i < 8; i++) send_frame(8'h21 + 8'(i), 1'b0, 1'b0);
    chk("full level", level, 8);
    send_frame(8'h29, 1'b0, 1'b1);
    exp_press += 9;
    chk("pushpop level", level, 8);
    chk("pushpop ovf", overflow, 0);
    chk("pushpop press", press_count, exp_press);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("pushpop drain%0d code", i), out_code, 8'h22 + 8'(i));
      pop_one();
    end
    chk("pushpop empty", out_valid, 0);

    // Timeout mid-frame after an E0 prefix: frame and decoder both abandoned
    send_frame(8'hE0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    chk("pre-timeout ferr", frame_err, 0);
    repeat (TO + 50) @(negedge clk);
    chk("timeout ferr", frame_err, 1);
    chk("timeout level", level, 0);
    send_frame(8'h29, 1'b0, 1'b0);
    exp_press++;
    chk("post-timeout valid", out_valid, 1);
    chk("post-timeout code", out_code, 8'h29);
    chk("post-timeout ext", out_ext, 0);
    chk("post-timeout brk", out_break, 0);
    chk("post-timeout press", press_count, exp_press);
    chk("post-timeout perr", parity_err, 0);
    pop_one();
    chk("ferr sticky", frame_err, 1);
    pulse_clr();
    chk("clr ferr", frame_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_rx_fifo.md
Name: ps2_kbd_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver, next generation of the team's single-stream PS/2 receiver. It deserialises PS/2 frames, decodes E0/F0 prefixes into make/break/extended flags and pushes one entry per key event into a configurable-depth FIFO. Consumers read the FIFO through a valid/ready handshake. The block sits between the board PS/2 pins and display/ASCII-lookup logic, and also provides sticky error flags and a key-press counter.

Parameters:
FIFO_DEPTH, 8, number of FIFO entries; power of two, 2..64
ADDR_W, 3, log2(FIFO_DEPTH); must match FIFO_DEPTH
TIMEOUT_CYC, 50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted
CNT_W, 8, width of press_count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ps2_clk  in  1  raw PS/2 clock, asynchronous to clk
ps2_data  in  1  raw PS/2 data
out_ready  in  1  consumer accepts the head entry
clr_err  in  1  synchronous clear of the sticky error flags
out_valid  out  1  FIFO non-empty; head entry is valid
out_code  out  8  scan code of the head entry
out_break  out  1  head entry is a release (F0 prefix seen)
out_ext  out  1  head entry is extended (E0 prefix seen)
level  out  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH
overflow  out  1  sticky; an event was dropped because the FIFO was full
parity_err  out  1  sticky; a frame failed the start, stop or odd-parity check
frame_err  out  1  sticky; a partial frame was aborted by timeout
press_count  out  CNT_W  count of accepted make (non-break) events; wraps

Behaviour:
- Reset (rst=0, asynchronous): all pointers, level, bit counter, decoder state, timeout counter, flags and press_count go to 0. out_valid=0. A 3-flop ps2_clk synchroniser resets to 3'b111 so no false edge is detected.
- Sampling: sample = sync[2] & ~sync[1]. Each sample stores ps2_data into buffer[count] and increments count, for counts 0..9.
- On the sample with count==10, the frame is checked: buffer[0]==0, ps2_data==1 and ^buffer[9:1]==1.
  - Pass: the byte buffer[8:1] goes to the decoder.
  - Fail: parity_err is set and the decoder state is unchanged.
  - In both cases count returns to 0.
- Timeout: while count!=0, a counter increments each clk and clears on every sample. When it reaches TIMEOUT_CYC-1, count returns to 0, frame_err is set and the decoder returns to IDLE.
- Decoder FSM. States are IDLE, E0, F0, E0F0. Transitions on each valid byte:
  - IDLE: 0xE0 goes to E0; 0xF0 goes to F0; any other byte pushes {ext=0, brk=0, code} and stays in IDLE.
  - E0: 0xF0 goes to E0F0; 0xE0 stays in E0; any other byte pushes {1, 0, code} and goes to IDLE.
  - F0: 0xF0 or 0xE0 goes to IDLE with no push (malformed sequence); any other byte pushes {0, 1, code} and goes to IDLE.
  - E0F0: 0xE0 or 0xF0 goes to IDLE with no push; any other byte pushes {1, 1, code} and goes to IDLE.
  - Prefix bytes are never pushed.
- FIFO: each entry is 10 bits {ext, brk, code}. The push happens at the clk edge where the final sample is processed. out_valid rises on the next cycle.
  - out_code, out_break and out_ext are read combinationally from mem[r_ptr].
  - Pop occurs when out_valid & out_ready at a clk edge.
  - Head outputs are stable while out_valid=1 and out_ready=0.
- Full: a push while level==FIFO_DEPTH with no simultaneous pop is dropped. overflow is set, and existing contents and pointers are untouched.
- A push and a pop in the same cycle are both performed, including when the FIFO is full. level is unchanged.
- Empty: out_ready is ignored and there is no pointer movement.
- Pointers are ADDR_W bits and wrap modulo FIFO_DEPTH. level is tracked separately, so full and empty are unambiguous. The FIFO is never flushed on drain.
- press_count increments by 1 on every accepted push with brk=0, wrapping from 2^CNT_W-1 to 0. Dropped pushes do not count.
- Flags: overflow, parity_err and frame_err are cleared synchronously by clr_err. If a set and clr_err occur in the same cycle, the set wins.
- Reset mid-frame: the partial frame is discarded and the FIFO is emptied.

Test Plan:
- Send frames 0x1C, 0xF0, 0x1C with out_ready=1 -> two entries: {code=0x1C, brk=0, ext=0} then {0x1C, 1, 0}; press_count 0->1; no error flags.
- Send 0xE0 0x75 then 0xE0 0xF0 0x75 -> entries {0x75, ext=1, brk=0} then {0x75, ext=1, brk=1}; press_count=1; level peaks at 1 when out_ready=1.
- Hold out_ready=0 and send 9 make codes 0x16..0x1E (FIFO_DEPTH=8) -> level=8, overflow=1, drained order 0x16..0x1D, 0x1E absent, press_count=8.
- Send 0x1C with a flipped parity bit -> no push, parity_err=1, level=0. Then pulse clr_err -> parity_err=0; a next good frame 0x1C is pushed normally.
- Send 5 clock edges then stop for TIMEOUT_CYC cycles -> frame_err=1, count back to 0. A following full frame 0x29 is received correctly.
- Use a full FIFO with out_ready=1 on the cycle a new frame completes -> pop and push both occur, level stays 8, overflow stays 0.
